// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock threshold FIFO.
// Defaults, count-width helper and error-flag bit positions for status words.
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 64;

  // Where overflow/underflow land when packed into a status aggregator word.
  localparam int STATUS_OVF_BIT = 0;
  localparam int STATUS_UNF_BIT = 1;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array with one write port and one registered read port.
// Array contents are never reset; only the read data register is.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Read data holds its value unless a read is accepted.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_th.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty thresholds
// and registered read port. Define SYNC_FIFO_ERR_EN to enable sticky overflow/underflow.
module sync_fifo_th
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             rempty,
  output logic [AW:0]      count,
  input  logic [AW:0]      af_thresh,
  input  logic [AW:0]      ae_thresh,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = count_width(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rvalid_q, rvalid_d;
  logic          wr_ok, rd_ok;

  assign wfull        = (count_q == CW'(DEPTH));
  assign rempty       = (count_q == '0);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign count        = count_q;
  assign rvalid       = rvalid_q;

  // Full/empty gating alone resolves the simultaneous-request corner cases.
  assign wr_ok = winc && !wfull && !rst;
  assign rd_ok = rinc && !rempty && !rst;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rvalid_d = rd_ok;
    if (wr_ok) wptr_d = wptr_q + AW'(1);
    if (rd_ok) rptr_d = rptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_ok),
    .waddr(wptr_q),
    .wdata(wdata),
    .re   (rd_ok),
    .raddr(rptr_q),
    .rdata(rdata)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Error flags look at the raw requests, so a rejected side still records.
  always_comb begin
    ovf_d = ovf_q | (winc & wfull);
    unf_d = unf_q | (rinc & rempty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
